// File: rtl/eic_io_controller_if.sv
// eic_io_controller_if: IO-bus and interrupt-request signals between the core and the
// external interrupt controller.
//   master - core side: drives IO strobes and write data, receives read data and Req/Id.
//   slave  - controller side: the reverse.
interface eic_io_controller_if;
    logic        IO_EnR;     // IO read strobe
    logic        IO_EnW;     // IO write strobe
    logic [31:0] IO_DataW;   // write data, valid while IO_EnW=1
    logic [31:0] IO_DataR;   // registered read data
    logic        EIC_I_Req;  // registered interrupt request
    logic        EIC_I_Id;   // registered source id, 0 = Irq_In[0]

    modport master (
        output IO_EnR,
        output IO_EnW,
        output IO_DataW,
        input  IO_DataR,
        input  EIC_I_Req,
        input  EIC_I_Id
    );

    modport slave (
        input  IO_EnR,
        input  IO_EnW,
        input  IO_DataW,
        output IO_DataR,
        output EIC_I_Req,
        output EIC_I_Id
    );
endinterface

// File: rtl/eic_io_controller.sv
// eic_io_controller: device-side end of the core's IO and external-interrupt interface.
// Two asynchronous interrupt lines are synchronized, their rising edges latched as
// pending, arbitrated (source 0 first) and presented as one stable Req/Id pair.
// IO writes carry clear/enable/set commands; IO reads return a status snapshot.
// Ports:
//   Sys_Clock - system clock, rising edge
//   Sys_Reset - synchronous active-high reset
//   Irq_In    - asynchronous active-high device interrupt lines
//   bus       - slave side of eic_io_controller_if (IO strobes, data, Req/Id)
module eic_io_controller #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [1:0]  RESET_ENABLE = 2'b00,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic                      Sys_Clock,
    input  logic                      Sys_Reset,
    input  logic [1:0]                Irq_In,
    eic_io_controller_if.slave        bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StGap    = 2'd2
    } state_e;

    localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]  delay_q, delay_d;
    logic [1:0]  pending_q, pending_d;
    logic [1:0]  overrun_q, overrun_d;
    logic [1:0]  enable_q, enable_d;
    logic [31:0] data_r_q, data_r_d;

    state_e      state_q;
    logic        req_q;
    logic        id_q;
    logic [3:0]  gap_q;

    logic [1:0]  sync_last;
    logic [1:0]  irq_edge;
    logic [1:0]  clr_cmd;
    logic [1:0]  set_cmd;
    logic [1:0]  active;
    logic [31:0] rd_word;
    logic        unused_dataw;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign irq_edge  = sync_last & ~delay_q;
    assign active    = pending_q & enable_q;

    // Only the command fields of the write word are decoded.
    assign unused_dataw = ^{bus.IO_DataW[31:26], bus.IO_DataW[23:18],
                            bus.IO_DataW[15:9], bus.IO_DataW[7:2]};

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], Irq_In};
        delay_d = sync_last;

        clr_cmd = bus.IO_EnW ? bus.IO_DataW[1:0]   : 2'b00;
        set_cmd = bus.IO_EnW ? bus.IO_DataW[25:24] : 2'b00;

        // Edge or SET wins over CLR for Pending; CLR always wins for Overrun.
        pending_d = (pending_q & ~clr_cmd) | irq_edge | set_cmd;
        overrun_d = (overrun_q | (irq_edge & pending_q)) & ~clr_cmd;

        enable_d = enable_q;
        if (bus.IO_EnW && bus.IO_DataW[8]) begin
            enable_d = bus.IO_DataW[17:16];
        end

        rd_word        = '0;
        rd_word[1:0]   = pending_q;
        rd_word[9:8]   = overrun_q;
        rd_word[17:16] = enable_q;
        rd_word[25:24] = sync_last;
        rd_word[29:28] = state_q;
        rd_word[31]    = req_q;

        data_r_d = bus.IO_EnR ? rd_word : data_r_q;
    end

    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            sync_q    <= '0;
            delay_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            enable_q  <= RESET_ENABLE;
            data_r_q  <= '0;
        end else begin
            sync_q    <= sync_d;
            delay_q   <= delay_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            enable_q  <= enable_d;
            data_r_q  <= data_r_d;
        end
    end

    // Request FSM. Id is latched on entry to StAssert and never re-arbitrated until
    // the granted source goes inactive; StGap enforces a minimum Req-low interval.
    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            id_q    <= 1'b0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (active != 2'b00) begin
                        state_q <= StAssert;
                        req_q   <= 1'b1;
                        id_q    <= ~active[0];
                    end
                end
                StAssert: begin
                    if (!active[id_q]) begin
                        state_q <= StGap;
                        req_q   <= 1'b0;
                        gap_q   <= GapLoad;
                    end
                end
                StGap: begin
                    if (gap_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IO_DataR  = data_r_q;
    assign bus.EIC_I_Req = req_q;
    assign bus.EIC_I_Id  = id_q;

endmodule

// File: tb/tb_eic_io_controller.sv
// tb_eic_io_controller: directed stimulus with a scoreboard. Stimulus pushes expected
// read data and expected Req/Id transitions (with the edge they must occur on); a
// monitor pops and compares whenever a read completes or Req/Id changes.
module tb_eic_io_controller;

    localparam int GapCycles = 3;

    typedef struct {
        int   cyc;
        logic req;
        logic id;
    } ev_t;

    logic       Sys_Clock = 1'b0;
    logic       Sys_Reset;
    logic [1:0] Irq_In;

    eic_io_controller_if bus();

    eic_io_controller #(
        .SYNC_STAGES  (2),
        .RESET_ENABLE (2'b00),
        .GAP_CYCLES   (GapCycles)
    ) dut (
        .Sys_Clock (Sys_Clock),
        .Sys_Reset (Sys_Reset),
        .Irq_In    (Irq_In),
        .bus       (bus)
    );

    always #5 Sys_Clock = ~Sys_Clock;

    ev_t         ev_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        rd_fire = 1'b0;
    logic        mon_en = 1'b0;
    logic [1:0]  prev = 2'b00;

    always @(posedge Sys_Clock) begin
        cyc     <= cyc + 1;
        rd_fire <= bus.IO_EnR;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge Sys_Clock) begin
        ev_t        e;
        logic [1:0] cur;
        if (mon_en) begin
            if (rd_fire) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h expected no read", bus.IO_DataR);
                end else begin
                    chk32("rd_data", bus.IO_DataR, rd_q.pop_front());
                end
            end
            cur = {bus.EIC_I_Req, bus.EIC_I_Id};
            if (cur !== prev) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected: got req/id %b expected no change (edge %0d)",
                             cur, cyc);
                end else begin
                    e = ev_q.pop_front();
                    chk32("req_id", {30'd0, cur}, {30'd0, e.req, e.id});
                    chk32("req_edge", cyc, e.cyc);
                end
                prev = cur;
            end
        end
    end

    task automatic tick();
        @(posedge Sys_Clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input logic [31:0] data);
        bus.IO_EnW   = 1'b1;
        bus.IO_DataW = data;
        tick();
        bus.IO_EnW   = 1'b0;
        bus.IO_DataW = '0;
    endtask

    task automatic rd(input logic [31:0] exp);
        rd_q.push_back(exp);
        bus.IO_EnR = 1'b1;
        tick();
        bus.IO_EnR = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] lines);
        Irq_In = lines;
        tick();
        Irq_In = 2'b00;
    endtask

    task automatic expect_ev(input int c, input logic r, input logic i);
        ev_t e;
        e.cyc = c;
        e.req = r;
        e.id  = i;
        ev_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int k;
        int m;
        Sys_Reset    = 1'b1;
        Irq_In       = 2'b00;
        bus.IO_EnR   = 1'b0;
        bus.IO_EnW   = 1'b0;
        bus.IO_DataW = '0;
        repeat (3) tick();
        Sys_Reset = 1'b0;
        chk32("reset_req", {31'd0, bus.EIC_I_Req}, 32'd0);
        chk32("reset_id", {31'd0, bus.EIC_I_Id}, 32'd0);
        chk32("reset_datar", bus.IO_DataR, 32'd0);
        prev   = 2'b00;
        mon_en = 1'b1;
        rd(32'h0000_0000);

        // Single pulse on line 1: Pending two edges after capture, Req one edge later.
        wr(32'h0003_0100);
        pulse(2'b10);
        k = cyc;
        expect_ev(k + 3, 1'b1, 1'b1);
        repeat (3) tick();
        rd(32'h9003_0002);
        wr(32'h0000_0002);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b1);
        wait_until(m + 6);

        // Both lines together: source 0 wins; after clear, gap then source 1.
        pulse(2'b11);
        k = cyc;
        expect_ev(k + 3, 1'b1, 1'b0);
        wait_until(k + 3);
        wr(32'h0000_0001);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b0);
        expect_ev(m + GapCycles + 2, 1'b1, 1'b1);
        wait_until(m + GapCycles + 2);

        // Higher-priority source arriving during ASSERT does not change Id.
        pulse(2'b01);
        repeat (3) tick();
        rd(32'h9003_0003);
        wr(32'h0000_0002);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b1);
        expect_ev(m + GapCycles + 2, 1'b1, 1'b0);
        wait_until(m + GapCycles + 2);
        wr(32'h0000_0001);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b0);
        wait_until(m + GapCycles + 2);

        // Overrun with interrupts disabled, then CLR coinciding with a new edge.
        wr(32'h0000_0100);
        pulse(2'b10);
        repeat (3) tick();
        pulse(2'b10);
        repeat (3) tick();
        rd(32'h0000_0202);
        pulse(2'b10);
        tick();
        wr(32'h0000_0002);
        rd(32'h0000_0002);

        // Enable/disable during ASSERT, pending retained, then software SET.
        wr(32'h0003_0100);
        m = cyc;
        expect_ev(m + 1, 1'b1, 1'b1);
        tick();
        wr(32'h0000_0100);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b1);
        wr(32'h0002_0100);
        expect_ev(m + GapCycles + 2, 1'b1, 1'b1);
        wait_until(m + GapCycles + 2);
        wr(32'h0000_0002);
        m = cyc;
        expect_ev(m + 1, 1'b0, 1'b1);
        wait_until(m + GapCycles + 2);
        wr(32'h0101_0100);
        m = cyc;
        expect_ev(m + 1, 1'b1, 1'b0);

        // Reset mid-ASSERT with both lines held high across and after reset.
        tick();
        Sys_Reset = 1'b1;
        Irq_In    = 2'b11;
        tick();
        m = cyc;
        expect_ev(m, 1'b0, 1'b0);
        chk32("midrst_datar", bus.IO_DataR, 32'd0);
        Sys_Reset = 1'b0;
        rd(32'h0000_0000);
        repeat (4) tick();
        rd(32'h0300_0003);
        wr(32'h0000_0003);
        repeat (3) tick();
        rd(32'h0300_0000);
        Irq_In = 2'b00;

        repeat (4) tick();
        chk32("ev_q_drained", ev_q.size(), 32'd0);
        chk32("rd_q_drained", rd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
